dmem_mmio_responder: RTL and testbench

// Responder side of the CPU data-memory bus (address, we, write data, read data).

---
 rtl/dmem_mmio_responder_if.sv | 19 +
 rtl/dmem_mmio_responder.sv | 107 ++++++++++
 tb/tb_dmem_mmio_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus between the single-cycle CPU and the responder, plus the
// TX byte stream toward the console sink.
//   we, a, wd : CPU write enable, byte address, write data
//   rd        : combinational read data back to the CPU
//   tx_valid/tx_data/tx_ready : valid/ready byte stream out of the TX FIFO
interface dmem_mmio_responder_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  // CPU plus sink side
  modport master (output we, a, wd, tx_ready, input rd, tx_valid, tx_data);
  // Responder side
  modport slave  (input we, a, wd, tx_ready, output rd, tx_valid, tx_data);
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus an MMIO window holding a TX byte FIFO,
// a FIFO status register and a free-running cycle timer.
// Ports:
//   clk   : rising-edge clock for all state
//   reset : asynchronous active-low reset (FIFO pointers/count, ovf, timer)
//   bus   : slave side of dmem_mmio_responder_if (CPU bus + TX stream)
// Reads are combinational so the single-cycle CPU sees data in the same cycle.
module dmem_mmio_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h100
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_mmio_responder_if.slave  bus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Register window decoded on word address a[31:2]
  localparam logic [29:0] TXDATA_WA = MMIO_BASE[31:2];
  localparam logic [29:0] STATUS_WA = MMIO_BASE[31:2] + 30'd1;
  localparam logic [29:0] TIMER_WA  = MMIO_BASE[31:2] + 30'd2;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  logic [31:0]      mem_q  [RAM_WORDS];
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic [31:0]      timer_q,  timer_d;

  logic [29:0]       word_addr;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit, tx_hit, stat_hit, timer_hit;
  logic              empty, full, pop, push_req, push;
  logic              unused_addr_lsbs;

  assign word_addr        = bus.a[31:2];
  assign ram_idx          = bus.a[2 +: RAM_AW];
  assign unused_addr_lsbs = ^bus.a[1:0];

  assign ram_hit   = word_addr < 30'(RAM_WORDS);
  assign tx_hit    = word_addr == TXDATA_WA;
  assign stat_hit  = word_addr == STATUS_WA;
  assign timer_hit = word_addr == TIMER_WA;

  assign empty = count_q == '0;
  assign full  = count_q == DEPTH;

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = fifo_q[rd_ptr_q];

  always_comb begin
    pop      = !empty && bus.tx_ready;
    push_req = bus.we && tx_hit;
    // A pop in the same cycle frees the slot a full FIFO needs for the push
    push     = push_req && (!full || pop);

    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Set has priority over a clear landing in the same cycle
    ovf_d = ovf_q;
    if (bus.we && stat_hit && bus.wd[2]) ovf_d = 1'b0;
    if (push_req && !push)               ovf_d = 1'b1;

    // A load replaces that cycle's increment
    timer_d = (bus.we && timer_hit) ? bus.wd : timer_q + 32'd1;
  end

  always_comb begin
    bus.rd = 32'h0;
    if (ram_hit)        bus.rd = mem_q[ram_idx];
    else if (stat_hit)  bus.rd = {16'b0, 8'(count_q), 5'b0, ovf_q, full, empty};
    else if (timer_hit) bus.rd = timer_q;
  end

  // RAM and FIFO storage are not reset; FIFO contents are discarded by
  // clearing the pointers and count.
  always_ff @(posedge clk) begin
    if (bus.we && ram_hit) mem_q[ram_idx] <= bus.wd;
    if (push)              fifo_q[wr_ptr_q] <= bus.wd[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      timer_q  <= 32'h0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a behavioural model.
module tb_dmem_mmio_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .RAM_WORDS (64),
    .FIFO_DEPTH(8),
    .MMIO_BASE (32'h100)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram    [64];
  bit          m_ram_ok [64];
  logic [7:0]  m_q [$];
  bit          m_ovf   = 1'b0;
  logic [31:0] m_timer = 32'h0;

  always @(posedge clk or negedge rst_n) begin : model
    bit          pop;
    logic [29:0] w;
    if (!rst_n) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_timer = 32'h0;
    end else begin
      pop = (m_q.size() != 0) && bus.tx_ready;
      w   = bus.a[31:2];
      if (pop) void'(m_q.pop_front());
      if (bus.we) begin
        if (w < 64) begin
          m_ram[w[5:0]]    = bus.wd;
          m_ram_ok[w[5:0]] = 1'b1;
        end
        if (w == 30'h40) begin
          if (m_q.size() < 8) m_q.push_back(bus.wd[7:0]);
          else                m_ovf = 1'b1;
        end
        if (w == 30'h41 && bus.wd[2]) m_ovf = 1'b0;
      end
      if (bus.we && w == 30'h42) m_timer = bus.wd;
      else                       m_timer = m_timer + 32'd1;
    end
  end

  // Expected read data; returns 0 when the value is unknowable (unwritten RAM)
  function automatic bit m_rd(input logic [31:0] addr, output logic [31:0] v);
    logic [29:0] w;
    int          n;
    w = addr[31:2];
    n = m_q.size();
    v = 32'h0;
    if (w < 64) begin
      v = m_ram[w[5:0]];
      return m_ram_ok[w[5:0]];
    end
    if (w == 30'h41) v = (n << 8) | (m_ovf ? 4 : 0) | (n == 8 ? 2 : 0) | (n == 0 ? 1 : 0);
    if (w == 30'h42) v = m_timer;
    return 1'b1;
  endfunction

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin : compare
    logic [31:0] ev;
    bit          known;
    checks++;
    if (bus.tx_valid !== (m_q.size() != 0)) begin
      errors++;
      $display("FAIL model_tx_valid t=%0t got %b expected %b", $time, bus.tx_valid, m_q.size() != 0);
    end
    if (m_q.size() != 0) begin
      checks++;
      if (bus.tx_data !== m_q[0]) begin
        errors++;
        $display("FAIL model_tx_data t=%0t got %h expected %h", $time, bus.tx_data, m_q[0]);
      end
    end
    known = m_rd(bus.a, ev);
    if (known) begin
      checks++;
      if (bus.rd !== ev) begin
        errors++;
        $display("FAIL model_rd t=%0t a=%h got %h expected %h", $time, bus.a, bus.rd, ev);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] dt);
    bus.a  = ad;
    bus.wd = dt;
    bus.we = 1'b1;
    cyc();
    bus.we = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [31:0] ad, input logic [31:0] exp);
    bus.a = ad;
    #1;
    chk(nm, bus.rd, exp);
  endtask

  logic [7:0] exp_q [$];

  task automatic drain(input string nm);
    bus.tx_ready = 1'b1;
    while (exp_q.size() != 0) begin
      chk({nm, "_valid"}, 32'(bus.tx_valid), 32'h1);
      chk({nm, "_data"},  32'(bus.tx_data),  32'(exp_q[0]));
      void'(exp_q.pop_front());
      cyc();
    end
    chk({nm, "_empty"}, 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;
  endtask

  logic [31:0] atab [8];

  initial begin
    bus.we = 1'b0; bus.a = 32'h0; bus.wd = 32'h0; bus.tx_ready = 1'b0;
    atab = '{32'h0, 32'h54, 32'hFC, 32'h100, 32'h100, 32'h104, 32'h108, 32'h1F0};

    // Reset state
    #1;
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
    rdchk("reset_status", 32'h104, 32'h1);
    rdchk("reset_timer",  32'h108, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // RAM and unmapped
    wr(32'h54, 32'hDEADBEEF);
    rdchk("ram_rd",   32'h54,  32'hDEADBEEF);
    rdchk("unmapped", 32'h1F0, 32'h0);

    // Basic FIFO ordering
    wr(32'h100, 32'h41); wr(32'h100, 32'h42); wr(32'h100, 32'h43);
    rdchk("status_3", 32'h104, 32'h0300);
    exp_q = '{8'h41, 8'h42, 8'h43};
    drain("fifo3");

    // Overflow: ninth byte lost, ovf sticky until cleared
    for (int i = 0; i < 9; i++) wr(32'h100, 32'h10 + 32'(i));
    rdchk("status_ovf", 32'h104, 32'h0806);
    wr(32'h104, 32'h4);
    rdchk("status_clr", 32'h104, 32'h0802);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    drain("ovf");

    // Full with push and pop in the same cycle
    for (int i = 1; i <= 8; i++) wr(32'h100, 32'(i));
    rdchk("status_full", 32'h104, 32'h0802);
    bus.a = 32'h100; bus.wd = 32'h99; bus.we = 1'b1; bus.tx_ready = 1'b1;
    #1;
    chk("pushpop_head", 32'(bus.tx_data), 32'h01);
    cyc();
    bus.we = 1'b0; bus.tx_ready = 1'b0;
    rdchk("pushpop_status", 32'h104, 32'h0802);
    for (int i = 2; i <= 8; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h99);
    drain("pushpop");

    // Timer counting from reset and wrap after load
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    rdchk("timer_10", 32'h108, 32'd10);
    wr(32'h108, 32'hFFFFFFFE);
    cyc(); cyc();
    rdchk("timer_wrap", 32'h108, 32'h0);

    // Asynchronous reset while draining
    for (int i = 0; i < 5; i++) wr(32'h100, 32'h60 + 32'(i));
    bus.tx_ready = 1'b1;
    bus.a = 32'h108;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
    rdchk("arst_status", 32'h104, 32'h1);
    rdchk("arst_timer",  32'h108, 32'h0);
    rdchk("arst_ram",    32'h54,  32'hDEADBEEF);
    cyc();
    rst_n = 1'b1;
    chk("arst_after", 32'(bus.tx_valid), 32'h0);
    bus.tx_ready = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      bus.a = (sel == 0) ? {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))} : atab[sel];
      bus.we = $urandom_range(0, 1) == 1;
      bus.wd = $urandom;
      bus.tx_ready = $urandom_range(0, 9) < 3;
      cyc();
    end
    bus.we = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
